// File: rtl/significand_packer.sv
// Packs sign, unbiased exponent and normalized significand into
// IEEE-754 double or single storage, denormalizing one bit per cycle.
module significand_packer #(
    parameter int EW        = 13,
    parameter int MAX_SHIFT = 54
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          db,
    input  logic          s,
    input  logic [EW-1:0] e,
    input  logic [52:0]   f,
    input  logic          nan,
    input  logic          inf,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   y,
    output logic          inexact,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int CW = $clog2(MAX_SHIFT + 1);
    localparam int XW = EW + 2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [52:0]   sig;
    logic          sticky;
    logic          db_q;
    logic          s_q;

    // Two guard bits so both e+bias and 1-eb stay exact.
    logic signed [XW-1:0] e_x;
    logic signed [XW-1:0] bias;
    logic signed [XW-1:0] emax;
    logic signed [XW-1:0] eb;
    logic signed [XW-1:0] sh;
    logic [CW-1:0]        cnt_load;
    logic                 lo_sticky;
    logic [52:0]          sig_nx;
    logic                 sticky_nx;

    assign e_x  = {{2{e[EW-1]}}, e};
    assign bias = db ? XW'(1023) : XW'(127);
    assign emax = db ? XW'(2047) : XW'(255);
    assign eb   = e_x + bias;
    assign sh   = XW'(1) - eb;

    assign cnt_load = (sh > XW'(MAX_SHIFT)) ? CW'(MAX_SHIFT)
                                            : sh[CW-1:0];
    assign lo_sticky = ~db & (|f[28:0]);

    assign sig_nx    = sig >> 1;
    assign sticky_nx = sticky | sig[0];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    function automatic logic [63:0] pack(
        input logic        dbl,
        input logic        sgn,
        input logic [10:0] ex,
        input logic [52:0] m
    );
        if (dbl)
            return {sgn, ex, m[51:0]};
        else
            return {sgn, ex[7:0], m[51:29], 32'b0};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sig       <= '0;
            sticky    <= 1'b0;
            db_q      <= 1'b0;
            s_q       <= 1'b0;
            y         <= '0;
            inexact   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        db_q      <= db;
                        s_q       <= s;
                        inexact   <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        state     <= DONE;
                        if (nan) begin
                            y <= pack(db, 1'b0, 11'h7FF,
                                      53'h08000000000000);
                        end else if (inf) begin
                            y <= pack(db, s, 11'h7FF, '0);
                        end else if (f == '0) begin
                            y <= {s, 63'b0};
                        end else if (eb >= emax) begin
                            y        <= pack(db, s, 11'h7FF, '0);
                            overflow <= 1'b1;
                            inexact  <= 1'b1;
                        end else if (eb > 0) begin
                            y       <= pack(db, s, eb[10:0], f);
                            inexact <= lo_sticky;
                        end else begin
                            cnt    <= cnt_load;
                            sig    <= f;
                            sticky <= lo_sticky;
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sig    <= sig_nx;
                    sticky <= sticky_nx;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        y         <= pack(db_q, s_q, 11'd0, sig_nx);
                        inexact   <= sticky_nx;
                        underflow <= sticky_nx;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
